// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer and the display translator.
package countdown_timer_pkg;

   // Countdown value width, also used by the 7-segment translator.
   localparam int CD_W = 5;

   // Timer control states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Free-running divider that strobes once every DIV enabled cycles.
module tick_prescaler #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Wrap indicator: only meaningful while counting is enabled.
   assign tick = en && (cnt_q == LAST);

   // Next count: clear wins, hold when disabled, wrap at DIV-1.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/countdown_timer.sv
// Loadable start/pause countdown feeding the two-digit display translator.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int TICK_HZ  = 1,
   parameter int CD_INIT  = 30
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [CD_W-1:0] load_val,
   input  logic            start,
   input  logic            pause,
   output logic [CD_W-1:0] CD,
   output logic            running,
   output logic            tick,
   output logic            expired
);

   localparam int DIV = CLK_FREQ / TICK_HZ;

   state_e          state_q, state_d;
   logic [CD_W-1:0] cd_q, cd_d;
   logic            running_q, running_d;
   logic            tick_q, tick_d;
   logic            expired_q, expired_d;
   logic            presc_en, presc_clr, presc_tick;

   // Prescaler advances only in RUN when neither load nor pause intervenes;
   // it restarts from zero on any load and on a fresh start out of IDLE.
   assign presc_en  = (state_q == RUN) && !load && !pause;
   assign presc_clr = load || ((state_q == IDLE) && start && (cd_q != '0));

   tick_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (presc_en),
      .clr  (presc_clr),
      .tick (presc_tick)
   );

   // Next state, countdown value and output strobes (load > pause > start).
   always_comb begin
      state_d   = state_q;
      cd_d      = cd_q;
      tick_d    = 1'b0;
      expired_d = 1'b0;
      if (load) begin
         cd_d    = load_val;
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && (cd_q != '0)) state_d = RUN;
            end
            RUN: begin
               if (pause) begin
                  state_d = PAUSE;
               end else if (presc_tick) begin
                  tick_d = 1'b1;
                  if (cd_q > CD_W'(1)) begin
                     cd_d = cd_q - CD_W'(1);
                  end else begin
                     cd_d      = '0;
                     expired_d = (cd_q == CD_W'(1));
                     state_d   = DONE;
                  end
               end
            end
            PAUSE: begin
               if (start && !pause) state_d = RUN;
            end
            default: begin
               state_d = DONE;
            end
         endcase
      end
      running_d = (state_d == RUN);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cd_q      <= CD_W'(CD_INIT);
         running_q <= 1'b0;
         tick_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cd_q      <= cd_d;
         running_q <= running_d;
         tick_q    <= tick_d;
         expired_q <= expired_d;
      end
   end

   assign CD      = cd_q;
   assign running = running_q;
   assign tick    = tick_q;
   assign expired = expired_q;

endmodule
